// File: rtl/rng2d_pkg.sv
// Shared types and defaults for the 2D rejection-sampling point generator.
package rng2d_pkg;

    localparam int X_MAX_DEF     = 320;
    localparam int Y_MAX_DEF     = 240;
    localparam int XW_DEF        = 9;
    localparam int YW_DEF        = 8;
    localparam int MAX_TRIES_DEF = 8;
    localparam int REJECT_CNT_W  = 16;

    typedef enum logic [2:0] {
        IDLE,
        GET_X,
        GET_Y,
        OUT,
        FIN
    } sampler_state_t;

    // Saturating increment for the rejection statistics counter.
    function automatic logic [REJECT_CNT_W-1:0] sat_inc(input logic [REJECT_CNT_W-1:0] v);
        return (v == {REJECT_CNT_W{1'b1}}) ? v : v + REJECT_CNT_W'(1);
    endfunction

endpackage

// File: rtl/bounded_pick.sv
// Per-axis candidate evaluation: accept when below the bound, otherwise signal
// a fallback on the last permitted retry. The fallback value folds the
// candidate back into range by subtracting the bound; because the bound is
// above half the candidate range this cannot underflow.
module bounded_pick #(
    parameter int W         = 9,
    parameter int MAX       = 320,
    parameter int MAX_TRIES = 8,
    parameter int TW        = $clog2(MAX_TRIES + 1)
) (
    input  logic [W-1:0]  cand,
    input  logic [TW-1:0] tries,
    output logic          accept,
    output logic          fallback,
    output logic [W-1:0]  value
);

    // One extra bit so a bound of exactly 2^W still compares correctly.
    localparam logic [W:0]    MAX_EXT  = (W+1)'(MAX);
    localparam logic [TW-1:0] LAST_TRY = TW'(MAX_TRIES - 1);

    logic [W:0] cand_ext;

    assign cand_ext = {1'b0, cand};
    assign accept   = (cand_ext < MAX_EXT);
    assign fallback = !accept && (tries == LAST_TRY);
    assign value    = accept ? cand : W'(cand_ext - MAX_EXT);

endmodule

// File: rtl/rand_point_sampler.sv
// Turns the free-running RNG word into bounded (x, y) points by rejection
// sampling with a bounded-retry fallback, and serves a burst of points per
// start request over a valid/ready stream.
module rand_point_sampler
    import rng2d_pkg::*;
#(
    parameter int X_MAX     = X_MAX_DEF,
    parameter int Y_MAX     = Y_MAX_DEF,
    parameter int XW        = XW_DEF,
    parameter int YW        = YW_DEF,
    parameter int MAX_TRIES = MAX_TRIES_DEF
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [15:0]             rand_data,
    input  logic                    start,
    input  logic [7:0]              count,
    output logic                    busy,
    output logic                    pt_valid,
    input  logic                    pt_ready,
    output logic [XW-1:0]           pt_x,
    output logic [YW-1:0]           pt_y,
    output logic                    pt_last,
    output logic                    done,
    output logic [REJECT_CNT_W-1:0] reject_cnt
);

    localparam int TW = $clog2(MAX_TRIES + 1);

    sampler_state_t          state;
    logic [7:0]              remaining;
    logic [TW-1:0]           tries;
    logic [REJECT_CNT_W-1:0] rej_cnt_q;

    logic [XW-1:0] cx;
    logic [YW-1:0] cy;
    logic          x_accept, x_fallback;
    logic          y_accept, y_fallback;
    logic [XW-1:0] x_value;
    logic [YW-1:0] y_value;

    // x uses the low bits of the word, y the high bits; the fields may overlap
    // because each axis consumes a different cycle's word.
    assign cx = rand_data[XW-1:0];
    assign cy = rand_data[15:16-YW];

    bounded_pick #(
        .W         (XW),
        .MAX       (X_MAX),
        .MAX_TRIES (MAX_TRIES),
        .TW        (TW)
    ) x_pick (
        .cand     (cx),
        .tries    (tries),
        .accept   (x_accept),
        .fallback (x_fallback),
        .value    (x_value)
    );

    bounded_pick #(
        .W         (YW),
        .MAX       (Y_MAX),
        .MAX_TRIES (MAX_TRIES),
        .TW        (TW)
    ) y_pick (
        .cand     (cy),
        .tries    (tries),
        .accept   (y_accept),
        .fallback (y_fallback),
        .value    (y_value)
    );

    assign busy       = (state != IDLE);
    assign done       = (state == FIN);
    assign pt_last    = pt_valid && (remaining == 8'd1);
    assign reject_cnt = rej_cnt_q;

    // Burst sequencer: retry tracking, point registers, handshake and reject statistics.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            remaining <= 8'd0;
            tries     <= '0;
            rej_cnt_q <= '0;
            pt_valid  <= 1'b0;
            pt_x      <= '0;
            pt_y      <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        remaining <= count;
                        state     <= (count != 8'd0) ? GET_X : FIN;
                    end
                end
                GET_X: begin
                    if (!x_accept) begin
                        rej_cnt_q <= sat_inc(rej_cnt_q);
                    end
                    if (x_accept || x_fallback) begin
                        pt_x  <= x_value;
                        tries <= '0;
                        state <= GET_Y;
                    end else begin
                        tries <= tries + TW'(1);
                    end
                end
                GET_Y: begin
                    if (!y_accept) begin
                        rej_cnt_q <= sat_inc(rej_cnt_q);
                    end
                    if (y_accept || y_fallback) begin
                        pt_y     <= y_value;
                        tries    <= '0;
                        pt_valid <= 1'b1;
                        state    <= OUT;
                    end else begin
                        tries <= tries + TW'(1);
                    end
                end
                OUT: begin
                    if (pt_ready) begin
                        remaining <= remaining - 8'd1;
                        pt_valid  <= 1'b0;
                        state     <= (remaining == 8'd1) ? FIN : GET_X;
                    end
                end
                FIN: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_rand_point_sampler.sv
// Directed bench for rand_point_sampler with a scoreboard-based point monitor.
module tb_rand_point_sampler;

    typedef struct {
        logic [8:0] x;
        logic [7:0] y;
        logic       last;
    } pt_t;

    logic        clk;
    logic        rst;
    logic [15:0] rand_data;
    logic        start;
    logic [7:0]  count;
    logic        busy;
    logic        pt_valid;
    logic        pt_ready;
    logic [8:0]  pt_x;
    logic [7:0]  pt_y;
    logic        pt_last;
    logic        done;
    logic [15:0] reject_cnt;

    int tests = 0;
    int fails = 0;
    int hs_cnt = 0;
    int done_cnt = 0;

    pt_t         exp_q[$];
    logic [15:0] rand_q[$];

    logic       stall_prev = 1'b0;
    logic [8:0] hold_x;
    logic [7:0] hold_y;
    logic       hold_last;

    rand_point_sampler dut (
        .clk        (clk),
        .rst        (rst),
        .rand_data  (rand_data),
        .start      (start),
        .count      (count),
        .busy       (busy),
        .pt_valid   (pt_valid),
        .pt_ready   (pt_ready),
        .pt_x       (pt_x),
        .pt_y       (pt_y),
        .pt_last    (pt_last),
        .done       (done),
        .reject_cnt (reject_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, time %0t", $time);
        $fatal(1);
    end

    // Monitor: pops the scoreboard on every handshake, checks stall stability, counts done pulses.
    always @(negedge clk) begin
        if (rst) begin
            stall_prev = 1'b0;
        end else begin
            if (stall_prev) begin
                tests++;
                if (!(pt_valid === 1'b1 && pt_x === hold_x && pt_y === hold_y && pt_last === hold_last)) begin
                    fails++;
                    $display("FAIL stall_stable: got v=%0b x=%0d y=%0d last=%0b expected v=1 x=%0d y=%0d last=%0b",
                             pt_valid, pt_x, pt_y, pt_last, hold_x, hold_y, hold_last);
                end
            end
            if (pt_valid === 1'b1 && pt_ready === 1'b1) begin
                hs_cnt++;
                tests++;
                if (exp_q.size() == 0) begin
                    fails++;
                    $display("FAIL unexpected_point: got x=%0d y=%0d last=%0b expected no point", pt_x, pt_y, pt_last);
                end else begin
                    pt_t e;
                    e = exp_q.pop_front();
                    if (pt_x !== e.x || pt_y !== e.y || pt_last !== e.last) begin
                        fails++;
                        $display("FAIL point: got x=%0d y=%0d last=%0b expected x=%0d y=%0d last=%0b",
                                 pt_x, pt_y, pt_last, e.x, e.y, e.last);
                    end
                end
            end
            stall_prev = (pt_valid === 1'b1) && (pt_ready === 1'b0);
            hold_x     = pt_x;
            hold_y     = pt_y;
            hold_last  = pt_last;
            if (done === 1'b1) done_cnt++;
        end
    end

    task automatic tick();
        @(posedge clk);
        #2;
        start = 1'b0;
        if (rand_q.size() > 0) rand_data = rand_q.pop_front();
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
        tests++;
        if (act !== expv) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", name, act, expv);
        end
    endtask

    task automatic push_pt(input logic [8:0] x, input logic [7:0] y, input logic last);
        pt_t p;
        p.x = x;
        p.y = y;
        p.last = last;
        exp_q.push_back(p);
    endtask

    task automatic wait_done(input string name, input int budget);
        int n = 0;
        while (done !== 1'b1 && n < budget) begin
            tick();
            n++;
        end
        tests++;
        if (done !== 1'b1) begin
            fails++;
            $display("FAIL %s: got no done expected done within %0d cycles", name, budget);
        end
        tick();
    endtask

    initial begin
        int hs0;
        int dn0;
        logic saw_done;

        rst       = 1'b1;
        rand_data = 16'h0000;
        start     = 1'b0;
        count     = 8'd0;
        pt_ready  = 1'b0;

        // Reset state
        tick();
        tick();
        check("rst_busy",   32'(busy),       32'd0);
        check("rst_valid",  32'(pt_valid),   32'd0);
        check("rst_done",   32'(done),       32'd0);
        check("rst_last",   32'(pt_last),    32'd0);
        check("rst_rejcnt", 32'(reject_cnt), 32'd0);
        rst = 1'b0;
        tick();

        // Accept path: x=319, y=239 on the first try, pt_valid in cycle 3
        rand_data = 16'hEF3F;
        pt_ready  = 1'b1;
        push_pt(9'd319, 8'd239, 1'b1);
        tick();
        start = 1'b1;
        count = 8'd1;
        tick();
        check("acc_busy_c1", 32'(busy), 32'd1);
        tick();
        check("acc_valid_c2", 32'(pt_valid), 32'd0);
        tick();
        check("acc_valid_c3", 32'(pt_valid), 32'd1);
        check("acc_last_c3",  32'(pt_last),  32'd1);
        tick();
        check("acc_done_c4", 32'(done), 32'd1);
        check("acc_busy_c4", 32'(busy), 32'd1);
        tick();
        check("acc_done_c5", 32'(done), 32'd0);
        check("acc_busy_c5", 32'(busy), 32'd0);
        check("acc_rejcnt",  32'(reject_cnt), 32'd0);

        // Boundary reject: x 0x140 twice then 0, y 0xF0 rejected then 0x10
        rand_data = 16'h0000;
        push_pt(9'd0, 8'd16, 1'b1);
        tick();
        start = 1'b1;
        count = 8'd1;
        rand_q.push_back(16'h0140);
        rand_q.push_back(16'h0140);
        rand_q.push_back(16'h0000);
        rand_q.push_back(16'hF000);
        rand_q.push_back(16'h1000);
        tick();
        tick();
        tick();
        tick();
        check("bnd_rejcnt_x", 32'(reject_cnt), 32'd2);
        tick();
        check("bnd_valid_c5", 32'(pt_valid), 32'd0);
        tick();
        check("bnd_valid_c6", 32'(pt_valid), 32'd1);
        wait_done("bnd_done", 20);
        check("bnd_rejcnt", 32'(reject_cnt), 32'd3);

        // Fallback: all-ones word forces 8 rejects per axis
        rand_data = 16'hFFFF;
        push_pt(9'd191, 8'd15, 1'b1);
        tick();
        start = 1'b1;
        count = 8'd1;
        for (int i = 1; i <= 16; i++) tick();
        check("fb_valid_c16", 32'(pt_valid), 32'd0);
        tick();
        check("fb_valid_c17", 32'(pt_valid), 32'd1);
        wait_done("fb_done", 20);
        check("fb_rejcnt", 32'(reject_cnt), 32'd19);
        check("fb_sb_empty", 32'(exp_q.size()), 32'd0);

        // Reset mid-burst while a point is stalled in OUT
        rand_data = 16'hEF3F;
        pt_ready  = 1'b0;
        tick();
        start = 1'b1;
        count = 8'd2;
        tick();
        tick();
        tick();
        check("mid_valid_pre", 32'(pt_valid), 32'd1);
        dn0 = done_cnt;
        rst = 1'b1;
        #1;
        check("mid_valid",  32'(pt_valid),   32'd0);
        check("mid_busy",   32'(busy),       32'd0);
        check("mid_done",   32'(done),       32'd0);
        check("mid_rejcnt", 32'(reject_cnt), 32'd0);
        check("mid_ptx",    32'(pt_x),       32'd0);
        tick();
        rst = 1'b0;
        exp_q.delete();
        tick();
        tick();
        tick();
        check("mid_no_done", 32'(done_cnt - dn0), 32'd0);
        check("mid_idle",    32'(busy),           32'd0);

        // Backpressure burst of 3 with toggling ready; start during burst ignored
        rand_data = 16'hEF3F;
        pt_ready  = 1'b0;
        push_pt(9'd319, 8'd239, 1'b0);
        push_pt(9'd319, 8'd239, 1'b0);
        push_pt(9'd319, 8'd239, 1'b1);
        hs0 = hs_cnt;
        dn0 = done_cnt;
        saw_done = 1'b0;
        tick();
        start = 1'b1;
        count = 8'd3;
        for (int i = 0; i < 60; i++) begin
            tick();
            pt_ready = ~pt_ready;
            if (i == 2) begin
                start = 1'b1;
                count = 8'd5;
            end
            if (done === 1'b1) begin
                saw_done = 1'b1;
                break;
            end
        end
        check("bp_done_seen", 32'(saw_done), 32'd1);
        pt_ready = 1'b1;
        tick();
        tick();
        tick();
        check("bp_handshakes", 32'(hs_cnt - hs0),   32'd3);
        check("bp_done_cnt",   32'(done_cnt - dn0), 32'd1);
        check("bp_idle",       32'(busy),           32'd0);
        check("bp_sb_empty",   32'(exp_q.size()),   32'd0);

        // count=0: done without any point
        hs0 = hs_cnt;
        dn0 = done_cnt;
        tick();
        start = 1'b1;
        count = 8'd0;
        for (int i = 0; i < 4; i++) begin
            tick();
            check("zero_no_valid", 32'(pt_valid), 32'd0);
        end
        check("zero_done_cnt", 32'(done_cnt - dn0), 32'd1);
        check("zero_no_hs",    32'(hs_cnt - hs0),   32'd0);
        check("zero_idle",     32'(busy),           32'd0);

        // Saturation: preload 0xFFFE, then 3 rejects
        dut.rej_cnt_q = 16'hFFFE;
        tick();
        check("sat_preload", 32'(reject_cnt), 32'hFFFE);
        rand_data = 16'h0000;
        push_pt(9'd0, 8'd16, 1'b1);
        tick();
        start = 1'b1;
        count = 8'd1;
        rand_q.push_back(16'h0140);
        rand_q.push_back(16'h0140);
        rand_q.push_back(16'h0000);
        rand_q.push_back(16'hF000);
        rand_q.push_back(16'h1000);
        tick();
        tick();
        tick();
        tick();
        check("sat_after_x", 32'(reject_cnt), 32'hFFFF);
        wait_done("sat_done", 20);
        check("sat_final",    32'(reject_cnt),   32'hFFFF);
        check("sat_sb_empty", 32'(exp_q.size()), 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
